// File: rtl/omux_pkg.sv
// Shared definitions for the host output-port arbiter: FSM encoding and
// header-byte construction.
package omux_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HDR  = 2'd1,
      ST_BODY = 2'd2
   } omux_st_e;

   localparam logic [3:0] TAG_HI_DEF = 4'hA;

   // Header layout: tag nibble, a reserved zero bit, then the source index.
   function automatic logic [7:0] hdr_byte(input logic [3:0] tag, input logic [2:0] src);
      return {tag, 1'b0, src};
   endfunction

endpackage

// File: rtl/omux_arbiter_rr_pick.sv
// Round-robin search: first eligible source strictly after the pointer,
// wrapping modulo N_SRC.
module rr_pick #(
   parameter int N_SRC = 2
) (
   input  logic [N_SRC-1:0] i_elig,
   input  logic [2:0]       i_ptr,
   output logic [2:0]       o_idx,
   output logic             o_vld
);

   logic [7:0] w_elig;
   logic [3:0] w_k;

   always_comb begin
      w_elig = '0;
      w_elig[N_SRC-1:0] = i_elig;
      o_idx = '0;
      o_vld = 1'b0;
      w_k   = '0;
      // ptr < N_SRC and offset <= N_SRC, so a single subtract wraps the sum.
      for (int i = 1; i <= N_SRC; i++) begin
         w_k = {1'b0, i_ptr} + 4'(i);
         if (w_k >= 4'(N_SRC)) w_k = w_k - 4'(N_SRC);
         if (!o_vld && w_elig[w_k[2:0]]) begin
            o_vld = 1'b1;
            o_idx = w_k[2:0];
         end
      end
   end

endmodule

// File: rtl/omux_arbiter.sv
// Shares the single host byte-output port among N_SRC byte streams, one
// tagged, atomic packet at a time in round-robin order.
module omux_arbiter
   import omux_pkg::*;
#(
   parameter int         N_SRC   = 2,
   parameter int         MAX_PKT = 32,
   parameter logic [3:0] TAG_HI  = TAG_HI_DEF
) (
   input  logic                 clk_i,
   input  logic                 reset_n_i,
   input  logic [N_SRC-1:0]     src_en_i,
   input  logic [N_SRC-1:0]     src_req_i,
   input  logic [N_SRC-1:0]     src_last_i,
   input  logic [8*N_SRC-1:0]   src_data_i,
   output logic [N_SRC-1:0]     src_sel_o,
   output logic                 omux_req_o,
   input  logic                 omux_sel_i,
   output logic [7:0]           omux_data_o,
   output logic [2:0]           grant_o,
   output logic                 busy_o,
   output logic                 err_o,
   input  logic                 err_clr_i
);

   omux_st_e   r_st;
   logic [2:0] r_grant;
   logic [2:0] r_rr_ptr;
   logic [7:0] r_cnt;
   logic       r_busy;
   logic       r_err;

   logic [7:0]      w_req_pad;
   logic [7:0]      w_last_pad;
   logic [7:0]      w_sel_pad;
   logic [7:0][7:0] w_data_pad;
   logic [2:0]      w_pick;
   logic            w_pick_vld;
   logic            w_acc;
   logic            w_last;
   logic            w_trunc;

   // Pad per-source vectors to 8 so a 3-bit grant can index them for any N_SRC.
   always_comb begin
      w_req_pad  = '0;
      w_last_pad = '0;
      w_data_pad = '0;
      w_req_pad[N_SRC-1:0]  = src_req_i;
      w_last_pad[N_SRC-1:0] = src_last_i;
      for (int k = 0; k < N_SRC; k++) w_data_pad[k] = src_data_i[8*k +: 8];
   end

   rr_pick #(.N_SRC(N_SRC)) u_rr_pick (
      .i_elig (src_req_i & src_en_i),
      .i_ptr  (r_rr_ptr),
      .o_idx  (w_pick),
      .o_vld  (w_pick_vld)
   );

   assign w_acc   = (r_st == ST_BODY) & omux_sel_i & w_req_pad[r_grant];
   assign w_last  = w_last_pad[r_grant];
   assign w_trunc = w_acc & ~w_last & (r_cnt == 8'(MAX_PKT-1));

   always_comb begin
      omux_req_o  = 1'b0;
      omux_data_o = 8'h00;
      w_sel_pad   = '0;
      case (r_st)
         ST_HDR: begin
            omux_req_o  = 1'b1;
            omux_data_o = hdr_byte(TAG_HI, r_grant);
         end
         ST_BODY: begin
            omux_req_o         = w_req_pad[r_grant];
            omux_data_o        = w_data_pad[r_grant];
            w_sel_pad[r_grant] = w_acc;
         end
         default: ;
      endcase
   end

   assign src_sel_o = w_sel_pad[N_SRC-1:0];
   assign grant_o   = r_grant;
   assign busy_o    = r_busy;
   assign err_o     = r_err;

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_st     <= ST_IDLE;
         r_grant  <= '0;
         r_rr_ptr <= 3'(N_SRC-1);
         r_cnt    <= '0;
         r_busy   <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         if (w_trunc)        r_err <= 1'b1;
         else if (err_clr_i) r_err <= 1'b0;

         case (r_st)
            ST_IDLE: begin
               if (w_pick_vld) begin
                  r_grant <= w_pick;
                  r_cnt   <= '0;
                  r_busy  <= 1'b1;
                  r_st    <= ST_HDR;
               end
            end
            ST_HDR: begin
               if (omux_sel_i) r_st <= ST_BODY;
            end
            ST_BODY: begin
               if (w_acc) begin
                  if (r_cnt != 8'hFF) r_cnt <= r_cnt + 8'd1;
                  // A truncated packet ends like a normal one; the rest of the
                  // stream re-arbitrates and gets a fresh header.
                  if (w_last || w_trunc) begin
                     r_rr_ptr <= r_grant;
                     r_busy   <= 1'b0;
                     r_st     <= ST_IDLE;
                  end
               end
            end
            default: begin
               r_busy <= 1'b0;
               r_st   <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/omux_arbiter.md
# omux_arbiter

Shares the host interface's single byte-output port (`omux_*` req/sel/data handshake) among up to 8 byte-stream sources, for example the record buffer and register-readback or status streams. It grants one source at a time in round-robin order and keeps each packet atomic. Every packet is prefixed with a one-byte tag so the host can demultiplex the streams. It sits between `host_iface` and the sources, and takes its enable mask from a configuration register.

## Interface
- `N_SRC`, default 2: number of sources, 1..8.
- `MAX_PKT`, default 32: maximum body bytes per packet before forced termination, 1..255.
- `TAG_HI`, default 4'hA: upper nibble of the header byte.

- `clk_i`  in  1  single clock domain.
- `reset_n_i`  in  1  asynchronous, active-low reset.
- `src_en_i`  in  N_SRC  per-source enable, from a config register.
- `src_req_i`  in  N_SRC  source has a byte available.
- `src_last_i`  in  N_SRC  the presented byte is the last of its packet.
- `src_data_i`  in  8*N_SRC  source bytes; source k occupies bits [8k+7:8k].
- `src_sel_o`  out  N_SRC  one-cycle pop strobe to the granted source.
- `omux_req_o`  out  1  byte available to host_iface.
- `omux_sel_i`  in  1  host_iface consumes `omux_data_o` this cycle.
- `omux_data_o`  out  8  byte to host_iface.
- `grant_o`  out  3  index of the current or last granted source.
- `busy_o`  out  1  a packet is in progress.
- `err_o`  out  1  sticky flag: a packet was truncated at MAX_PKT.
- `err_clr_i`  in  1  clears `err_o`.

## Operation
- Eligible source k: `src_req_i[k] & src_en_i[k]`.
- State register `st` takes one of three states: IDLE, HDR, BODY.
- IDLE
  - If any source is eligible, pick the first eligible index after `rr_ptr`, wrapping modulo N_SRC.
  - Register the choice into `grant`, clear `cnt`, go to HDR.
  - Otherwise stay in IDLE.
- HDR
  - `omux_req_o=1`, `omux_data_o={TAG_HI,1'b0,grant}`.
  - On `omux_sel_i`, go to BODY. `src_sel_o` stays 0 in this state.
- BODY
  - `omux_req_o=src_req_i[grant]`, `omux_data_o=src_data_i[grant]`.
  - `src_sel_o[grant]=omux_sel_i & src_req_i[grant]`; all other bits are 0.
  - Each accepted byte increments `cnt`. `cnt` is 8 bits and saturates.
  - If an accepted byte has `src_last_i[grant]`, set `rr_ptr<=grant` and go to IDLE.
  - If the accepted byte is number MAX_PKT and `src_last_i[grant]` is not set, set `err_o`, set `rr_ptr<=grant`, and go to IDLE. The remainder of that source's data goes out as a new packet later.
  - If `src_req_i[grant]` drops mid-packet, BODY stalls with `omux_req_o=0` and the grant is held; no other source is serviced.
  - Clearing `src_en_i[grant]` mid-packet has no effect until the packet ends.
- An `omux_sel_i` arriving while `omux_req_o=0` is ignored: no pop, no state change.
- `busy_o` = (st != IDLE). `grant_o` = `grant`.
- `err_o`: setting it takes priority over `err_clr_i` in the same cycle.
- Reset values: st=IDLE, grant=0, rr_ptr=N_SRC-1 (so source 0 wins first), cnt=0, err_o=0.
  - In IDLE: `omux_req_o=0`, `omux_data_o=8'h00`, `src_sel_o=0`.

## Timing
- `src_sel_o` and the BODY-state `omux_req_o`/`omux_data_o` are combinational from `omux_sel_i` and the source inputs. All other outputs are registered.
- Arbitration latency: eligibility seen in IDLE at cycle t, so HDR is valid at t+1.
- Minimum packet cost: 1 arbitration cycle + 1 header byte + n body bytes. There is no dead cycle between body bytes.
- After a packet ends, IDLE lasts exactly one cycle before the next HDR.
- Asynchronous reset mid-packet aborts the packet immediately. The host sees a truncated stream, and the next packet starts with a fresh header.

## Structure
- Shared package `omux_pkg` holds:
  - the state encoding (IDLE=2'd0, HDR=2'd1, BODY=2'd2);
  - the header nibble constant;
  - a function building the header byte.
- One sub-module, `rr_pick`: combinational round-robin first-eligible-after-pointer search, parameterized by N_SRC. It returns the index and a valid bit.
- The data mux and state machine live in the top level.

## Test plan
- Reset, then src0 presents 3 bytes (11,22,33; last on 33). Host output must be A0,11,22,33; `src_sel_o[0]` pulses 3 times; `busy_o` returns to 0 one cycle after the 33 sel.
- src0 and src1 both request continuously with 2-byte packets. Headers must alternate A0,A1,A0,A1, and no packet may be interleaved with another.
- src1 drops req for 5 cycles mid-packet while src0 requests. `omux_req_o` must be 0 for those 5 cycles, src0 must not be granted, and the packet then resumes.
- MAX_PKT=4 and src0 streams 6 bytes with last on byte 6. Output must be A0,b1..b4,A0,b5,b6; `err_o`=1 until `err_clr_i`.
- `src_en_i[0]`=0 while src0 and src1 request. Only A1 packets appear. Re-enabling src0 mid-packet of src1 takes effect at the next arbitration.
- `reset_n_i` asserted mid-BODY. All outputs return to reset values asynchronously, and the first post-reset packet from src0 begins with A0.
